// File: rtl/mini_alu_core_pkg.sv
// Shared definitions for mini_alu_core: instruction word layout and opcodes.
// Instruction word: [27:24] opcode, [23:16] dest/target, [15:8] src1, [7:0] src0.
package mini_alu_core_pkg;

  localparam int INSTR_W = 28;
  localparam int OPC_W   = 4;
  localparam int FLD_W   = 8;
  localparam int OPC_LSB = 24;
  localparam int DST_LSB = 16;
  localparam int S1_LSB  = 8;
  localparam int S0_LSB  = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'd0,
    OP_STO  = 4'd1,
    OP_BLE  = 4'd2,
    OP_BGE  = 4'd3,
    OP_JMP  = 4'd4,
    OP_ADD  = 4'd5,
    OP_INC  = 4'd6,
    OP_CALL = 4'd7,
    OP_RET  = 4'd8,
    OP_VGA  = 4'd9,
    OP_SUB  = 4'd10,
    OP_BEQ  = 4'd11
  } opcode_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for mini_alu_core.
// Ports: clk_i/rst_i (async active-high), push_i/data_i write a new top,
// pop_i discards the top, top_o shows the current top, full_o/empty_o/level_o
// report occupancy. Push when full and pop when empty are ignored.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     top_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [AW-1:0]    wr_idx, top_idx;

  assign full_o  = (lvl_q == LVL_W'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;
  assign wr_idx  = AW'(lvl_q);
  assign top_idx = AW'(lvl_q - LVL_W'(1));
  assign top_o   = mem_q[top_idx];

  always_comb begin
    lvl_d = lvl_q;
    if (push_i && !full_o)      lvl_d = lvl_q + LVL_W'(1);
    else if (pop_i && !empty_o) lvl_d = lvl_q - LVL_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lvl_q <= '0;
    else       lvl_q <= lvl_d;
  end

  // Entries carry no reset: only slots below the level are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/mini_alu_core.sv
// mini_alu_core: two-step (fetch/decode, execute) ALU sequencer.
// Ports: Clock, Reset (async active-high), iRun (0 freezes the core),
// iInstruction (ROM data for oIP), oIP (fetch address incl. branch redirect),
// oVgaWe/oVgaAddr/oVgaData (pixel write), oFault (sticky stack error),
// oStackLevel (return stack occupancy).
module mini_alu_core
  import mini_alu_core_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int IP_W        = 16,
  parameter int REG_COUNT   = 8,
  parameter int STACK_DEPTH = 4,
  parameter int PIXEL_W     = 3
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               iRun,
  input  logic [INSTR_W-1:0]                 iInstruction,
  output logic [IP_W-1:0]                    oIP,
  output logic                               oVgaWe,
  output logic [15:0]                        oVgaAddr,
  output logic [PIXEL_W-1:0]                 oVgaData,
  output logic                               oFault,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   oStackLevel
);

  localparam int RA_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  function automatic logic [RA_W-1:0] reg_idx(input logic [FLD_W-1:0] f);
    return RA_W'(int'(f) % REG_COUNT);
  endfunction

  logic [IP_W-1:0]   ip_q, ip_d, ex_ip_q;
  logic [OPC_W-1:0]  ex_op_q;
  logic [FLD_W-1:0]  ex_dest_q, ex_src1_q, ex_src0_q;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] rf_q [REG_COUNT];
  logic [DATA_W-1:0] rd1, rd0, rf_wd;
  logic              rf_we, taken, push, pop, fault_set, is_vga;
  logic [IP_W-1:0]   target, stk_top;
  logic              stk_full, stk_empty;

  assign rd1 = rf_q[reg_idx(ex_src1_q)];
  assign rd0 = rf_q[reg_idx(ex_src0_q)];

  // ---- Execute stage: combinational from the decode register ----
  always_comb begin
    taken     = 1'b0;
    target    = IP_W'(ex_dest_q);
    rf_we     = 1'b0;
    rf_wd     = '0;
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = 1'b0;
    case (ex_op_q)
      OP_STO:  begin rf_we = 1'b1; rf_wd = DATA_W'({ex_src1_q, ex_src0_q}); end
      OP_BLE:  taken = (rd1 <= rd0);
      OP_BGE:  taken = (rd1 >= rd0);
      OP_JMP:  taken = 1'b1;
      OP_ADD:  begin rf_we = 1'b1; rf_wd = rd1 + rd0; end
      OP_INC:  begin rf_we = 1'b1; rf_wd = rd1 + DATA_W'(1); end
      OP_SUB:  begin rf_we = 1'b1; rf_wd = rd1 - rd0; end
      OP_BEQ:  taken = (rd1 == rd0);
      // A CALL that cannot push degrades to NOP and only raises the fault.
      OP_CALL: begin
        if (stk_full) fault_set = 1'b1;
        else begin push = 1'b1; taken = 1'b1; end
      end
      OP_RET: begin
        if (stk_empty) fault_set = 1'b1;
        else begin pop = 1'b1; taken = 1'b1; target = stk_top; end
      end
      default: ;
    endcase
  end

  // A stalled core must not redirect: oIP shows the held IP register.
  assign oIP     = (iRun && taken) ? target : ip_q;
  assign ip_d    = oIP + IP_W'(1);
  assign fault_d = fault_q | (iRun & fault_set);

  assign is_vga   = (ex_op_q == OP_VGA);
  assign oVgaWe   = iRun && is_vga;
  assign oVgaAddr = is_vga ? {rd1[7:0], rd0[7:0]} : 16'h0000;
  assign oVgaData = is_vga ? ex_dest_q[PIXEL_W-1:0] : '0;
  assign oFault   = fault_q;

  ret_stack #(.DEPTH(STACK_DEPTH), .W(IP_W)) u_stack (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (iRun & push),
    .pop_i   (iRun & pop),
    .data_i  (ex_ip_q + IP_W'(1)),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .level_o (oStackLevel)
  );

  // ---- Fetch/decode stage: IP and decode register ----
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ip_q      <= '0;
      ex_ip_q   <= '0;
      ex_op_q   <= OP_NOP;
      ex_dest_q <= '0;
      ex_src1_q <= '0;
      ex_src0_q <= '0;
      fault_q   <= 1'b0;
    end else if (iRun) begin
      ip_q      <= ip_d;
      ex_ip_q   <= oIP;
      ex_op_q   <= iInstruction[OPC_LSB +: OPC_W];
      ex_dest_q <= iInstruction[DST_LSB +: FLD_W];
      ex_src1_q <= iInstruction[S1_LSB +: FLD_W];
      ex_src0_q <= iInstruction[S0_LSB +: FLD_W];
      fault_q   <= fault_d;
    end
  end

  // Reset forces the decode register to NOP, so no write lands during reset.
  always_ff @(posedge Clock) begin
    if (iRun && rf_we) rf_q[reg_idx(ex_dest_q)] <= rf_wd;
  end

endmodule

// File: tb/tb_mini_alu_core.sv
module tb_mini_alu_core;

  localparam int DATA_W      = 16;
  localparam int IP_W        = 16;
  localparam int REG_COUNT   = 8;
  localparam int STACK_DEPTH = 2;
  localparam int PIXEL_W     = 3;
  localparam int LVL_W       = $clog2(STACK_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic [27:0]       instr;
  logic [IP_W-1:0]   ip;
  logic              we;
  logic [15:0]       vaddr;
  logic [PIXEL_W-1:0] vdata;
  logic              fault;
  logic [LVL_W-1:0]  lvl;

  logic [27:0] rom [256];
  assign instr = rom[ip[7:0]];

  always #5 clk = ~clk;

  mini_alu_core #(
    .DATA_W(DATA_W), .IP_W(IP_W), .REG_COUNT(REG_COUNT),
    .STACK_DEPTH(STACK_DEPTH), .PIXEL_W(PIXEL_W)
  ) dut (
    .Clock(clk), .Reset(rst), .iRun(run), .iInstruction(instr),
    .oIP(ip), .oVgaWe(we), .oVgaAddr(vaddr), .oVgaData(vdata),
    .oFault(fault), .oStackLevel(lvl)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] enc(input int op, input int d, input int s1, input int s0);
    return {4'(op), 8'(d), 8'(s1), 8'(s0)};
  endfunction

  // ISA-level model: instruction in flight, next sequential address,
  // architectural registers, return stack as a queue, sticky fault.
  logic [15:0] m_regs [REG_COUNT];
  logic [15:0] m_stack [$];
  logic [15:0] m_ip = 16'h0;
  logic [15:0] m_ex_addr = 16'h0;
  bit          m_ex_valid = 1'b0;
  bit          m_fault = 1'b0;

  typedef struct {
    bit          taken;
    logic [15:0] target;
    logic [15:0] fetch;
    bit          we;
    logic [15:0] addr;
    logic [2:0]  data;
  } mout_t;

  function automatic mout_t model_eval();
    mout_t o;
    logic [27:0] w;
    logic [3:0] op;
    logic [15:0] a, b;
    w  = m_ex_valid ? rom[m_ex_addr[7:0]] : 28'h0;
    op = w[27:24];
    a  = m_regs[int'(w[15:8]) % REG_COUNT];
    b  = m_regs[int'(w[7:0]) % REG_COUNT];
    o.taken  = 1'b0;
    o.target = {8'h00, w[23:16]};
    case (op)
      4'd2:  o.taken = (a <= b);
      4'd3:  o.taken = (a >= b);
      4'd4:  o.taken = 1'b1;
      4'd11: o.taken = (a == b);
      4'd7:  o.taken = (m_stack.size() < STACK_DEPTH);
      4'd8:  if (m_stack.size() > 0) begin
               o.taken  = 1'b1;
               o.target = m_stack[m_stack.size() - 1];
             end
      default: ;
    endcase
    o.fetch = (run && o.taken) ? o.target : m_ip;
    o.we    = run && (op == 4'd9);
    o.addr  = (op == 4'd9) ? {a[7:0], b[7:0]} : 16'h0;
    o.data  = (op == 4'd9) ? w[18:16] : 3'd0;
    return o;
  endfunction

  task automatic model_step();
    mout_t o;
    logic [27:0] w;
    logic [15:0] a, b;
    int di;
    o  = model_eval();
    w  = m_ex_valid ? rom[m_ex_addr[7:0]] : 28'h0;
    a  = m_regs[int'(w[15:8]) % REG_COUNT];
    b  = m_regs[int'(w[7:0]) % REG_COUNT];
    di = int'(w[23:16]) % REG_COUNT;
    case (w[27:24])
      4'd1:  m_regs[di] = w[15:0];
      4'd5:  m_regs[di] = a + b;
      4'd6:  m_regs[di] = a + 16'd1;
      4'd10: m_regs[di] = a - b;
      4'd7:  if (m_stack.size() < STACK_DEPTH) m_stack.push_back(m_ex_addr + 16'd1);
             else m_fault = 1'b1;
      4'd8:  if (m_stack.size() > 0) void'(m_stack.pop_back());
             else m_fault = 1'b1;
      default: ;
    endcase
    m_ex_addr  = o.fetch;
    m_ex_valid = 1'b1;
    m_ip       = o.fetch + 16'd1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ip = 16'h0; m_ex_addr = 16'h0; m_ex_valid = 1'b0; m_fault = 1'b0;
      m_stack.delete();
    end else if (run) begin
      model_step();
    end
  end

  always @(negedge clk) begin
    mout_t o;
    if (chk_en && !rst) begin
      o = model_eval();
      check("cmp_ip",    32'(ip),    32'(o.fetch));
      check("cmp_we",    32'(we),    32'(o.we));
      check("cmp_addr",  32'(vaddr), 32'(o.addr));
      check("cmp_data",  32'(vdata), 32'(o.data));
      check("cmp_fault", 32'(fault), 32'(m_fault));
      check("cmp_lvl",   32'(lvl),   32'(m_stack.size()));
    end
  end

  task automatic start_test();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_ip",    32'(ip),    32'h0);
    check("rst_we",    32'(we),    32'h0);
    check("rst_addr",  32'(vaddr), 32'h0);
    check("rst_data",  32'(vdata), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_lvl",   32'(lvl),   32'h0);
    for (int i = 0; i < 256; i++) rom[i] = 28'h0;
  endtask

  task automatic release_rst();
    run = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    // Arithmetic chain, back-to-back fetch.
    start_test();
    rom[0] = enc(1, 1, 0, 5);
    rom[1] = enc(1, 2, 0, 3);
    rom[2] = enc(5, 3, 1, 2);
    rom[3] = enc(6, 4, 3, 0);
    rom[4] = enc(9, 0, 4, 3);
    rom[5] = enc(4, 5, 0, 0);
    release_rst();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); check("t1_ip_seq", 32'(ip), 32'(k));
    end
    @(negedge clk);
    check("t1_we",   32'(we),    32'h1);
    check("t1_r4r3", 32'(vaddr), 32'h0908);
    check("t1_ip5",  32'(ip),    32'h5);

    // Taken BEQ, no delay slot.
    start_test();
    rom[0]  = enc(1, 1, 0, 2);
    rom[1]  = enc(1, 2, 0, 2);
    rom[2]  = enc(11, 10, 1, 2);
    rom[3]  = enc(9, 7, 1, 2);
    rom[10] = enc(9, 5, 1, 2);
    rom[11] = enc(4, 11, 0, 0);
    release_rst();
    repeat (4) @(negedge clk);
    check("t2_redirect", 32'(ip), 32'd10);
    check("t2_no_slot",  32'(we), 32'h0);
    @(negedge clk);
    check("t2_we",   32'(we),    32'h1);
    check("t2_addr", 32'(vaddr), 32'h0202);
    check("t2_data", 32'(vdata), 32'h5);

    // Nested CALL overflow at depth 2, then RET to 9.
    start_test();
    rom[0]  = enc(7, 8, 0, 0);
    rom[8]  = enc(7, 12, 0, 0);
    rom[9]  = enc(4, 9, 0, 0);
    rom[12] = enc(7, 16, 0, 0);
    rom[13] = enc(8, 0, 0, 0);
    rom[16] = enc(4, 16, 0, 0);
    release_rst();
    repeat (2) @(negedge clk);
    check("t3_call8", 32'(ip), 32'd8);
    @(negedge clk);
    check("t3_call12", 32'(ip),  32'd12);
    check("t3_lvl1",   32'(lvl), 32'd1);
    @(negedge clk);
    check("t3_ignored", 32'(ip),    32'd13);
    check("t3_lvl2",    32'(lvl),   32'd2);
    check("t3_nofault", 32'(fault), 32'h0);
    @(negedge clk);
    check("t3_ret9", 32'(ip),    32'd9);
    check("t3_ovf",  32'(fault), 32'h1);
    check("t3_lvl",  32'(lvl),   32'd2);
    @(negedge clk);
    check("t3_popped", 32'(lvl), 32'd1);

    // RET underflow, SUB wrap and 16-bit equality of the difference.
    start_test();
    rom[0]  = enc(8, 0, 0, 0);
    rom[1]  = enc(1, 1, 0, 3);
    rom[2]  = enc(1, 2, 0, 5);
    rom[3]  = enc(10, 0, 1, 2);
    rom[4]  = enc(1, 5, 8'hFF, 8'hFE);
    rom[5]  = enc(11, 20, 0, 5);
    rom[6]  = enc(9, 7, 0, 0);
    rom[20] = enc(9, 6, 0, 0);
    rom[21] = enc(4, 21, 0, 0);
    release_rst();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); check("t4_ip_seq", 32'(ip), 32'(k));
      if (k == 2) check("t4_unf", 32'(fault), 32'h1);
    end
    @(negedge clk);
    check("t4_beq_fffe", 32'(ip), 32'd20);
    @(negedge clk);
    check("t4_addr", 32'(vaddr), 32'hFEFE);
    check("t4_data", 32'(vdata), 32'h6);

    // Pixel write.
    start_test();
    rom[0] = enc(1, 1, 0, 8'h40);
    rom[1] = enc(1, 2, 0, 8'h20);
    rom[2] = enc(9, 5, 2, 1);
    rom[3] = enc(4, 3, 0, 0);
    release_rst();
    repeat (4) @(negedge clk);
    check("t5_we",   32'(we),    32'h1);
    check("t5_addr", 32'(vaddr), 32'h2040);
    check("t5_data", 32'(vdata), 32'h5);
    @(negedge clk);
    check("t5_we_one", 32'(we), 32'h0);

    // Stall with JMP in execute, resume, then asynchronous reset.
    start_test();
    rom[0] = enc(1, 1, 0, 0);
    rom[1] = enc(6, 1, 1, 0);
    rom[2] = enc(9, 0, 1, 1);
    rom[3] = enc(4, 1, 0, 0);
    release_rst();
    repeat (4) @(negedge clk);
    check("t6_addr1", 32'(vaddr), 32'h0101);
    @(posedge clk); #2;
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_stall_ip", 32'(ip), 32'd4);
      check("t6_stall_we", 32'(we), 32'h0);
    end
    @(posedge clk); #2;
    run = 1'b1;
    @(negedge clk);
    check("t6_resume", 32'(ip), 32'd1);
    repeat (2) @(negedge clk);
    check("t6_we",    32'(we),    32'h1);
    check("t6_addr2", 32'(vaddr), 32'h0202);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_ip",  32'(ip),    32'h0);
    check("t6_rst_we",  32'(we),    32'h0);
    check("t6_rst_lvl", 32'(lvl),   32'h0);
    check("t6_rst_adr", 32'(vaddr), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
